// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI widths, burst/response encodings and FSM state types
package axi_pkg;

    localparam int AXI_DW     = 128;
    localparam int AXI_AW     = 40;
    localparam int AXI_IW     = 8;
    localparam int AXI_LW     = 8;
    localparam int AXI_SW     = 3;
    localparam int AXI_BURSTW = 2;
    localparam int AXI_BRESPW = 2;
    localparam int AXI_RRESPW = 2;
    localparam int MEM_AW     = 10;
    localparam int AXI_BYTES  = AXI_DW / 8;
    localparam int AXI_WSTRBW = AXI_BYTES;
    localparam int AXI_LSB    = $clog2(AXI_BYTES);

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_slave_model_if.sv
// rtl/axi_slave_model_if.sv - AXI4 bus bundle with master and slave views
interface axi_slave_model_if;
    import axi_pkg::*;

    logic [AXI_IW-1:0]     AWID;
    logic [AXI_AW-1:0]     AWADDR;
    logic [AXI_LW-1:0]     AWLEN;
    logic [AXI_SW-1:0]     AWSIZE;
    logic [AXI_BURSTW-1:0] AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [AXI_DW-1:0]     WDATA;
    logic [AXI_WSTRBW-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [AXI_IW-1:0]     BID;
    logic [AXI_BRESPW-1:0] BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [AXI_IW-1:0]     ARID;
    logic [AXI_AW-1:0]     ARADDR;
    logic [AXI_LW-1:0]     ARLEN;
    logic [AXI_SW-1:0]     ARSIZE;
    logic [AXI_BURSTW-1:0] ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [AXI_IW-1:0]     RID;
    logic [AXI_DW-1:0]     RDATA;
    logic [AXI_RRESPW-1:0] RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

endinterface

// File: rtl/axi_addr_gen.sv
// rtl/axi_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_addr_gen
    import axi_pkg::*;
(
    input  logic [AXI_AW-1:0]     addr_i,
    input  logic [AXI_LW-1:0]     len_i,
    input  logic [AXI_SW-1:0]     size_i,
    input  logic [AXI_BURSTW-1:0] burst_i,
    output logic [AXI_AW-1:0]     next_o
);

    logic [AXI_AW-1:0] step;
    logic [AXI_AW-1:0] incr_addr;
    logic [AXI_AW-1:0] wrap_mask;

    always_comb begin
        step      = AXI_AW'(1) << size_i;
        incr_addr = addr_i + step;
        // window is (len+1)<<size bytes; only the bits inside it advance
        wrap_mask = ((AXI_AW'(len_i) + AXI_AW'(1)) << size_i) - AXI_AW'(1);
        case (burst_i)
            BURST_FIXED: next_o = addr_i;
            BURST_WRAP:  next_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_model.sv
// rtl/axi_slave_model.sv - AXI4 slave backed by a byte-enabled word memory
module axi_slave_model
    import axi_pkg::*;
(
    input  logic             ACLK,
    input  logic             ARESETn,
    axi_slave_model_if.slave s_axi
);

    localparam int HI = MEM_AW + AXI_LSB;

    logic [AXI_DW-1:0] mem [0:(1<<MEM_AW)-1];

    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [AXI_IW-1:0]     bid_q, bid_d;
    logic [AXI_BRESPW-1:0] bresp_q, bresp_d;
    logic [AXI_AW-1:0]     waddr_q, waddr_d;
    logic [AXI_LW-1:0]     wlen_q, wlen_d;
    logic [AXI_LW-1:0]     wcnt_q, wcnt_d;
    logic [AXI_SW-1:0]     wsize_q, wsize_d;
    logic [AXI_BURSTW-1:0] wburst_q, wburst_d;
    logic                  wdec_q, wdec_d;
    logic [AXI_AW-1:0]     waddr_next;
    logic                  mem_we;
    logic [MEM_AW-1:0]     w_idx;

    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [AXI_IW-1:0]     rid_q, rid_d;
    logic [AXI_DW-1:0]     rdata_q, rdata_d;
    logic [AXI_RRESPW-1:0] rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic [AXI_AW-1:0]     raddr_q, raddr_d;
    logic [AXI_LW-1:0]     rlen_q, rlen_d;
    logic [AXI_LW-1:0]     rcnt_q, rcnt_d;
    logic [AXI_SW-1:0]     rsize_q, rsize_d;
    logic [AXI_BURSTW-1:0] rburst_q, rburst_d;
    logic                  rdec_q, rdec_d;
    logic [AXI_AW-1:0]     raddr_next;
    logic [MEM_AW-1:0]     r_idx;
    logic [AXI_DW-1:0]     mem_rd;
    logic                  ar_dec;

    axi_addr_gen u_waddr_gen (
        .addr_i  (waddr_q),
        .len_i   (wlen_q),
        .size_i  (wsize_q),
        .burst_i (wburst_q),
        .next_o  (waddr_next)
    );

    axi_addr_gen u_raddr_gen (
        .addr_i  (raddr_q),
        .len_i   (rlen_q),
        .size_i  (rsize_q),
        .burst_i (rburst_q),
        .next_o  (raddr_next)
    );

    assign w_idx  = waddr_q[HI-1:AXI_LSB];
    assign ar_dec = |s_axi.ARADDR[AXI_AW-1:HI];
    // idle fetches the AR address; mid-burst prefetches the following beat
    assign r_idx  = (r_state_q == R_IDLE) ? s_axi.ARADDR[HI-1:AXI_LSB] : raddr_next[HI-1:AXI_LSB];
    assign mem_rd = mem[r_idx];

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wdec_d    = wdec_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awready_q && s_axi.AWVALID) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    bid_d     = s_axi.AWID;
                    waddr_d   = s_axi.AWADDR;
                    wlen_d    = s_axi.AWLEN;
                    wsize_d   = s_axi.AWSIZE;
                    wburst_d  = s_axi.AWBURST;
                    wdec_d    = |s_axi.AWADDR[AXI_AW-1:HI];
                    wcnt_d    = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wready_q && s_axi.WVALID) begin
                    mem_we  = !wdec_q;
                    waddr_d = waddr_next;
                    wcnt_d  = wcnt_q + 1'b1;
                    // either the counted last beat or an early WLAST closes the burst
                    if (wcnt_q == wlen_q || s_axi.WLAST) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        w_state_d = W_RESP;
                        if (wdec_q)
                            bresp_d = RESP_DECERR;
                        else if (wcnt_q != wlen_q || !s_axi.WLAST)
                            bresp_d = RESP_SLVERR;
                        else
                            bresp_d = RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rdec_d    = rdec_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arready_q && s_axi.ARVALID) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = s_axi.ARID;
                    raddr_d   = s_axi.ARADDR;
                    rlen_d    = s_axi.ARLEN;
                    rsize_d   = s_axi.ARSIZE;
                    rburst_d  = s_axi.ARBURST;
                    rcnt_d    = '0;
                    rdec_d    = ar_dec;
                    rdata_d   = ar_dec ? '0 : mem_rd;
                    rresp_d   = ar_dec ? RESP_DECERR : RESP_OKAY;
                    rlast_d   = (s_axi.ARLEN == '0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rdata_d   = '0;
                        rresp_d   = RESP_OKAY;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        raddr_d = raddr_next;
                        rcnt_d  = rcnt_q + 1'b1;
                        rdata_d = rdec_q ? '0 : mem_rd;
                        rlast_d = (rcnt_q + 1'b1 == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wdec_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rdec_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wdec_q    <= wdec_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rdec_q    <= rdec_d;
        end
    end

    // memory is deliberately unreset; a same-cycle read above sees the old word
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < AXI_BYTES; b++) begin
                if (s_axi.WSTRB[b])
                    mem[w_idx][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
            end
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BID     = bid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RID     = rid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
    assign s_axi.RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_slave_model.sv
// tb/tb_axi_slave_model.sv - directed bench with a burst-level memory model and per-cycle compare
module tb_axi_slave_model;

    localparam int WORDS      = 1024;
    localparam int BEAT_BYTES = 16;
    localparam int RANGE_BITS = 14;

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [7:0]   id;
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } r_exp_t;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    b_exp_t       b_q[$];
    r_exp_t       r_q[$];
    logic [127:0] mem_m [int];

    always #5 ACLK = ~ACLK;

    axi_slave_model_if s_if ();

    axi_slave_model dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .s_axi   (s_if)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint beat_addr(input longint start, input int len, input int size,
                                         input logic [1:0] burst, input int i);
        longint step;
        longint win;
        longint base;
        step = longint'(1) << size;
        case (burst)
            2'b00: return start;
            2'b10: begin
                win  = longint'(len + 1) * step;
                base = start - (start % win);
                return base + ((start - base + longint'(i) * step) % win);
            end
            default: return start + longint'(i) * step;
        endcase
    endfunction

    function automatic bit is_dec(input longint a);
        return (a >> RANGE_BITS) != 0;
    endfunction

    function automatic int widx(input longint a);
        return int'((a / BEAT_BYTES) % WORDS);
    endfunction

    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (s_if.BVALID) begin
                if (b_q.size() == 0) begin
                    chk("b_unexpected", 128'(s_if.BVALID), 128'(0));
                end else begin
                    chk("bid", 128'(s_if.BID), 128'(b_q[0].id));
                    chk("bresp", 128'(s_if.BRESP), 128'(b_q[0].resp));
                    if (s_if.BREADY) void'(b_q.pop_front());
                end
            end
            if (s_if.RVALID) begin
                if (r_q.size() == 0) begin
                    chk("r_unexpected", 128'(s_if.RVALID), 128'(0));
                end else begin
                    chk("rid", 128'(s_if.RID), 128'(r_q[0].id));
                    chk("rdata", s_if.RDATA, r_q[0].data);
                    chk("rresp", 128'(s_if.RRESP), 128'(r_q[0].resp));
                    chk("rlast", 128'(s_if.RLAST), 128'(r_q[0].last));
                    if (s_if.RREADY) void'(r_q.pop_front());
                end
            end
        end
    end

    task automatic do_write(input logic [7:0] id, input longint addr, input int len, input int size,
                            input logic [1:0] burst, input logic [127:0] base,
                            input logic [15:0] strb, input int wlast_at);
        int     nb;
        int     cyc;
        bit     dec;
        b_exp_t e;
        dec    = is_dec(addr);
        nb     = (wlast_at < len) ? wlast_at + 1 : len + 1;
        e.id   = id;
        e.resp = dec ? 2'b11 : ((wlast_at != len) ? 2'b10 : 2'b00);
        b_q.push_back(e);
        for (int i = 0; i < nb; i++) begin
            int           w;
            logic [127:0] d;
            logic [127:0] word;
            if (!dec) begin
                w    = widx(beat_addr(addr, len, size, burst, i));
                d    = base * 128'(i + 1);
                word = mem_m.exists(w) ? mem_m[w] : '0;
                for (int b = 0; b < 16; b++)
                    if (strb[b]) word[8*b +: 8] = d[8*b +: 8];
                mem_m[w] = word;
            end
        end
        s_if.AWID    = id;
        s_if.AWADDR  = 40'(addr);
        s_if.AWLEN   = 8'(len);
        s_if.AWSIZE  = 3'(size);
        s_if.AWBURST = burst;
        s_if.AWVALID = 1'b1;
        cyc = 0;
        @(negedge ACLK);
        while (!s_if.AWREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
        chk("aw_accept", 128'(s_if.AWREADY), 128'(1));
        @(posedge ACLK); #1;
        s_if.AWVALID = 1'b0;
        for (int i = 0; i < nb; i++) begin
            s_if.WDATA  = base * 128'(i + 1);
            s_if.WSTRB  = strb;
            s_if.WLAST  = (i == wlast_at);
            s_if.WVALID = 1'b1;
            cyc = 0;
            @(negedge ACLK);
            while (!s_if.WREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
            chk("w_accept", 128'(s_if.WREADY), 128'(1));
            @(posedge ACLK); #1;
        end
        s_if.WVALID = 1'b0;
        s_if.WLAST  = 1'b0;
        @(negedge ACLK);
        chk("b_latency", 128'(s_if.BVALID), 128'(1));
        @(negedge ACLK);
        chk("aw_ready_after_b", 128'(s_if.AWREADY), 128'(1));
        chk("b_drop", 128'(s_if.BVALID), 128'(0));
        chk("b_drained", 128'(b_q.size()), 128'(0));
        @(posedge ACLK); #1;
    endtask

    task automatic do_read(input logic [7:0] id, input longint addr, input int len, input int size,
                           input logic [1:0] burst, input bit rnd, input int abort_at);
        int     cyc;
        int     n_hs;
        bit     first;
        bit     dec;
        r_exp_t e;
        dec = is_dec(addr);
        for (int i = 0; i <= len; i++) begin
            int w;
            w      = widx(beat_addr(addr, len, size, burst, i));
            e.id   = id;
            e.data = dec ? '0 : (mem_m.exists(w) ? mem_m[w] : '0);
            e.resp = dec ? 2'b11 : 2'b00;
            e.last = (i == len);
            r_q.push_back(e);
        end
        s_if.RREADY  = 1'b1;
        s_if.ARID    = id;
        s_if.ARADDR  = 40'(addr);
        s_if.ARLEN   = 8'(len);
        s_if.ARSIZE  = 3'(size);
        s_if.ARBURST = burst;
        s_if.ARVALID = 1'b1;
        cyc = 0;
        @(negedge ACLK);
        while (!s_if.ARREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
        chk("ar_accept", 128'(s_if.ARREADY), 128'(1));
        @(posedge ACLK); #1;
        s_if.ARVALID = 1'b0;
        if (rnd) s_if.RREADY = 1'($urandom_range(0, 1));
        n_hs  = 0;
        cyc   = 0;
        first = 1'b1;
        while (n_hs < len + 1 && cyc < 400) begin
            @(negedge ACLK);
            if (first) chk("r_latency", 128'(s_if.RVALID), 128'(1));
            else if (!rnd) chk("r_fullrate", 128'(s_if.RVALID), 128'(1));
            first = 1'b0;
            if (s_if.RVALID && s_if.RREADY) n_hs++;
            if (abort_at > 0 && n_hs == abort_at) break;
            @(posedge ACLK); #1;
            if (rnd) s_if.RREADY = 1'($urandom_range(0, 1));
            cyc++;
        end
        if (abort_at <= 0) begin
            chk("r_beats", 128'(n_hs), 128'(len + 1));
            @(negedge ACLK);
            chk("r_drop", 128'(s_if.RVALID), 128'(0));
            chk("ar_ready_after_last", 128'(s_if.ARREADY), 128'(1));
            chk("r_drained", 128'(r_q.size()), 128'(0));
            @(posedge ACLK); #1;
            s_if.RREADY = 1'b1;
        end
    endtask

    initial begin
        s_if.AWID = '0; s_if.AWADDR = '0; s_if.AWLEN = '0; s_if.AWSIZE = '0; s_if.AWBURST = '0;
        s_if.AWVALID = 1'b0;
        s_if.WDATA = '0; s_if.WSTRB = '0; s_if.WLAST = 1'b0; s_if.WVALID = 1'b0;
        s_if.BREADY = 1'b1;
        s_if.ARID = '0; s_if.ARADDR = '0; s_if.ARLEN = '0; s_if.ARSIZE = '0; s_if.ARBURST = '0;
        s_if.ARVALID = 1'b0;
        s_if.RREADY = 1'b1;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", 128'(s_if.AWREADY), 128'(0));
        chk("rst_wready", 128'(s_if.WREADY), 128'(0));
        chk("rst_bvalid", 128'(s_if.BVALID), 128'(0));
        chk("rst_arready", 128'(s_if.ARREADY), 128'(0));
        chk("rst_rvalid", 128'(s_if.RVALID), 128'(0));
        chk("rst_rlast", 128'(s_if.RLAST), 128'(0));
        chk("rst_rdata", s_if.RDATA, 128'(0));
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("awready_pre_edge", 128'(s_if.AWREADY), 128'(0));
        @(posedge ACLK); #1;
        chk("awready_first_edge", 128'(s_if.AWREADY), 128'(1));
        chk("arready_first_edge", 128'(s_if.ARREADY), 128'(1));

        // model pins: WRAP order and INCR stepping computed by the bench's own address rule
        chk("model_wrap0", 128'(beat_addr(64'h230, 3, 4, 2'b10, 0)), 128'h230);
        chk("model_wrap1", 128'(beat_addr(64'h230, 3, 4, 2'b10, 1)), 128'h200);
        chk("model_wrap2", 128'(beat_addr(64'h230, 3, 4, 2'b10, 2)), 128'h210);
        chk("model_wrap3", 128'(beat_addr(64'h230, 3, 4, 2'b10, 3)), 128'h220);
        chk("model_incr3", 128'(beat_addr(64'h100, 3, 4, 2'b01, 3)), 128'h130);

        do_write(8'h5A, 64'h100, 3, 4, 2'b01, 128'h11, 16'hFFFF, 3);
        chk("model_mem_100", mem_m[16], 128'h11);
        chk("model_mem_130", mem_m[19], 128'h44);
        do_read(8'hA5, 64'h100, 3, 4, 2'b01, 1'b0, -1);

        do_write(8'h21, 64'h230, 3, 4, 2'b10, 128'h1000, 16'hFFFF, 3);
        chk("model_mem_200", mem_m[32], 128'h2000);
        do_read(8'h22, 64'h230, 3, 4, 2'b10, 1'b0, -1);
        do_read(8'h23, 64'h200, 3, 4, 2'b01, 1'b0, -1);

        do_write(8'h30, 64'h0, 1, 4, 2'b01, 128'h77, 16'hFFFF, 1);
        do_write(8'h33, 64'h1 << RANGE_BITS, 1, 4, 2'b01, 128'hDEAD, 16'hFFFF, 1);
        do_read(8'h34, 64'h1 << RANGE_BITS, 1, 4, 2'b01, 1'b0, -1);
        do_read(8'h35, 64'h0, 1, 4, 2'b01, 1'b0, -1);

        do_write(8'h44, 64'h500, 2, 4, 2'b01, 128'h55, 16'hFFFF, 1);
        do_write(8'h45, 64'h500, 0, 4, 2'b01, 128'h66, 16'hFFFF, 0);
        do_write(8'h48, 64'h600, 1, 4, 2'b01, 128'h5, 16'hFFFF, 5);
        do_read(8'h49, 64'h500, 1, 4, 2'b01, 1'b0, -1);
        do_read(8'h4A, 64'h600, 1, 4, 2'b01, 1'b0, -1);

        do_write(8'h46, 64'h300, 1, 4, 2'b00, 128'h99, 16'hFFFF, 1);
        do_read(8'h47, 64'h300, 1, 4, 2'b00, 1'b0, -1);
        do_write(8'h4B, 64'h100, 0, 4, 2'b01, {16{8'hAA}}, 16'h00FF, 0);
        chk("model_strobe", mem_m[16], {64'h0, {8{8'hAA}}});
        do_read(8'h4C, 64'h100, 0, 4, 2'b01, 1'b0, -1);

        do_write(8'h50, 64'h400, 15, 4, 2'b01, 128'h0101_0000, 16'hFFFF, 15);
        do_read(8'h51, 64'h400, 15, 4, 2'b01, 1'b1, -1);

        do_read(8'h60, 64'h400, 7, 4, 2'b01, 1'b0, 2);
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        #1;
        chk("abort_rvalid", 128'(s_if.RVALID), 128'(0));
        chk("abort_arready", 128'(s_if.ARREADY), 128'(0));
        chk("abort_awready", 128'(s_if.AWREADY), 128'(0));
        r_q.delete();
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("arready_pre_edge", 128'(s_if.ARREADY), 128'(0));
        @(posedge ACLK); #1;
        chk("arready_after_release", 128'(s_if.ARREADY), 128'(1));
        do_read(8'h61, 64'h100, 3, 4, 2'b01, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_slave_model.md
Name: axi_slave_model

Overview:
- AXI4 slave (responder) simulation model backed by an internal byte-enabled word memory.
- Serves as the far end for the AXI master model in block-level benches.
- Accepts one write burst and one read burst at a time, with independent write and read paths.
- Supports FIXED, INCR and WRAP bursts and returns OKAY, SLVERR or DECERR.

Parameters:
AXI_DW, 128, data bus width
AXI_AW, 40, address bus width
AXI_IW, 8, ID width
AXI_LW, 8, AxLEN width
AXI_SW, 3, AxSIZE width
AXI_BURSTW, 2, AxBURST width
AXI_BRESPW, 2, BRESP width
AXI_RRESPW, 2, RRESP width
MEM_AW, 10, memory word-address width (2**MEM_AW words of AXI_DW bits)
AXI_BYTES, AXI_DW/8, derived bytes per beat
AXI_WSTRBW, AXI_BYTES, derived strobe width

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  IW/AW/LW/SW/BURSTW  write address
AWVALID  in  1 ; AWREADY  out  1
WDATA/WSTRB/WLAST  in  DW/WSTRBW/1 ; WVALID  in  1 ; WREADY  out  1
BID/BRESP  out  IW/BRESPW ; BVALID  out  1 ; BREADY  in  1
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  IW/AW/LW/SW/BURSTW  read address
ARVALID  in  1 ; ARREADY  out  1
RID/RDATA/RRESP/RLAST  out  IW/DW/RRESPW/1 ; RVALID  out  1 ; RREADY  in  1

Behaviour:

Clock and reset:
- Single clock ACLK. Reset ARESETn is asynchronous, active-low.
- All outputs are registered. During reset every output is 0, including the READYs.
- AWREADY and ARREADY rise on the first ACLK edge after ARESETn deasserts.
- Memory contents are not reset.

Addressing:
- Word index = addr[MEM_AW+LSB-1:LSB], where LSB = log2(AXI_BYTES).
- A burst is DECERR if any address bit above MEM_AW+LSB is nonzero at AW/AR accept time. This is checked once per burst.
- Next address:
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: wraps within an aligned window of (len+1)<<size bytes.
- len is not checked for WRAP legality. Reserved burst type 2'b11 is treated as INCR.

Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
- W_IDLE: AWREADY=1. The AW handshake captures ID, addr, len, size and burst. WREADY=1 from the next cycle.
- W_DATA, per beat:
  - On each W handshake, write the bytes where WSTRB=1 to the current word. No write if DECERR.
  - Then advance the address and the beat counter.
- Last beat: the beat with count==len ends the burst.
  - WLAST=0 on that beat, or WLAST=1 on an earlier beat, flags SLVERR.
  - An early WLAST ends the burst immediately.
- W_RESP: BVALID=1 the cycle after the last beat, with BID = captured ID. BRESP precedence: DECERR, then SLVERR, then OKAY.
- BVALID holds with stable BID/BRESP until BREADY. Return to W_IDLE the cycle after the B handshake; AWREADY=1 in that cycle.

Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
- R_IDLE: ARREADY=1. The AR handshake at cycle N gives the first beat with RVALID=1 at N+1.
- R_DATA:
  - RDATA = full memory word. RDATA=0 and RRESP=DECERR for out-of-range bursts.
  - RLAST=1 only when count==len.
- Backpressure: RVALID, RDATA, RRESP, RLAST and RID are stable while RREADY=0.
- Throughput: a handshake at cycle t presents the next beat at t+1. Back-to-back beats run at full rate.
- After the RLAST handshake: RVALID=0 and return to R_IDLE, ARREADY=1 next cycle.

Concurrency and limits:
- A simultaneous read and write to the same word in the same cycle returns the pre-write data.
- One outstanding burst per direction. AxREADY stays low while that direction is busy.
- Narrow transfers are supported via WSTRB; lane masking on the read side is the master's job.
- An ARESETn assertion mid-burst aborts both FSMs to IDLE and drops all VALIDs immediately.

Decomposition:
- Shared package axi_pkg:
  - burst enum FIXED/INCR/WRAP
  - resp constants OKAY/EXOKAY/SLVERR/DECERR
  - write/read FSM state enums
- One sub-module, axi_addr_gen: purely combinational next-address from addr, size, len and burst. It has two instances, one for write and one for read.

Test Plan:
1. AW INCR addr 0x100, len 3, size 4; 4 W beats of 0x11..0x44, WSTRB all ones -> BVALID one cycle after the 4th beat, BRESP=OKAY, BID echoed. AR to the same burst -> RDATA 0x11,0x22,0x33,0x44 on 4 consecutive cycles, RLAST on the 4th only.
2. WRAP len 3, size 4, addr 0x230 -> write/read order 0x230,0x200,0x210,0x220. Readback matches.
3. AWADDR 1<<(MEM_AW+LSB), len 1 -> both beats accepted, memory unchanged, BRESP=DECERR. Matching read -> 2 beats RRESP=DECERR, RDATA=0.
4. WLAST on beat 1 of a len-2 burst -> burst ends, BRESP=SLVERR. The next AW is accepted normally.
5. RREADY random 50% during a len-15 read -> RDATA/RLAST stable under stall, 16 beats in order, one RLAST.
6. ARESETn pulsed low mid-read (beat 2 of 8) -> RVALID=0 at once. After release ARREADY=1 next edge; a new read completes correctly.
